// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet TX constants (minimum frame length, arbiter state and grant encodings)
package eth_pkg;
  localparam int ETH_MIN_FRAME = 60;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ARP = 2'd1;
  localparam state_t IP = 2'd2;
  localparam state_t PAD = 2'd3;
  localparam logic GRANT_ARP = 1'b0;
  localparam logic GRANT_IP = 1'b1;
endpackage

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-wise ARP/IP AXIS merge into registered MAC stream, zero-padding short frames to MIN_FRAME
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = ETH_MIN_FRAME,
  parameter int CNT_W = 11
) (
  input  logic       tx_mac_aclk,
  input  logic       tx_mac_reset,
  input  logic [7:0] s_arp_tdata,
  input  logic       s_arp_tvalid,
  input  logic       s_arp_tlast,
  output logic       s_arp_tready,
  input  logic [7:0] s_ip_tdata,
  input  logic       s_ip_tvalid,
  input  logic       s_ip_tlast,
  output logic       s_ip_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  input  logic       m_tready
);
  state_t state, state_nxt;
  logic last_grant, last_grant_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [CNT_W:0] cnt_p1;
  logic [7:0] tdata_nxt, in_data;
  logic tvalid_nxt, tlast_nxt, adv, hs, pad, in_last, end_in, full, done;
  assign adv = !m_tvalid || m_tready;
  assign s_arp_tready = (state == ARP) && adv;
  assign s_ip_tready = (state == IP) && adv;
  assign hs = (s_arp_tready && s_arp_tvalid) || (s_ip_tready && s_ip_tvalid);
  assign pad = (state == PAD) && adv;
  assign in_data = state == IP ? s_ip_tdata : s_arp_tdata;
  assign in_last = state == IP ? s_ip_tlast : s_arp_tlast;
  assign end_in = hs && in_last;
  assign cnt_p1 = {1'b0, byte_cnt} + (CNT_W+1)'(1);
  assign full = cnt_p1 >= (CNT_W+1)'(MIN_FRAME);
  assign done = (pad || end_in) && full;
  always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
    if (tx_mac_reset) begin
      state <= IDLE;
      last_grant <= GRANT_IP;
      byte_cnt <= '0;
      m_tdata <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
    end else begin
      state <= state_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt <= byte_cnt_nxt;
      m_tdata <= tdata_nxt;
      m_tvalid <= tvalid_nxt;
      m_tlast <= tlast_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    last_grant_nxt = last_grant;
    if (state == IDLE) begin
      if (s_arp_tvalid && s_ip_tvalid) begin
        state_nxt = last_grant == GRANT_ARP ? IP : ARP;
        last_grant_nxt = last_grant == GRANT_ARP ? GRANT_IP : GRANT_ARP;
      end else if (s_arp_tvalid) state_nxt = ARP;
      else if (s_ip_tvalid) state_nxt = IP;
    end else if (end_in || pad) state_nxt = full ? IDLE : PAD;
  end
  always_comb begin
    tdata_nxt = m_tdata;
    tvalid_nxt = m_tvalid;
    tlast_nxt = m_tlast;
    byte_cnt_nxt = byte_cnt;
    if (hs || pad) begin
      tdata_nxt = hs ? in_data : 8'h00;
      tvalid_nxt = 1'b1;
      tlast_nxt = done;
      byte_cnt_nxt = done ? '0 : (&byte_cnt ? byte_cnt : cnt_p1[CNT_W-1:0]);
    end else if (adv) begin
      tvalid_nxt = 1'b0;
      tlast_nxt = 1'b0;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;
  logic tx_mac_aclk = 1'b0;
  logic tx_mac_reset;
  logic [7:0] s_arp_tdata, s_ip_tdata, m_tdata;
  logic s_arp_tvalid, s_arp_tlast, s_arp_tready;
  logic s_ip_tvalid, s_ip_tlast, s_ip_tready;
  logic m_tvalid, m_tlast, m_tready;
  int total = 0;
  int bad = 0;
  logic [7:0] arp_q[$];
  logic [7:0] ip_q[$];
  logic [8:0] out_q[$];
  bit rnd;
  int cyc, arp_n, ip_n, out_n, tl_n, early_ip, first_ip, first_valid, k;
  always #5 tx_mac_aclk = ~tx_mac_aclk;
  eth_tx_arbiter dut (
    .tx_mac_aclk(tx_mac_aclk), .tx_mac_reset(tx_mac_reset),
    .s_arp_tdata(s_arp_tdata), .s_arp_tvalid(s_arp_tvalid), .s_arp_tlast(s_arp_tlast), .s_arp_tready(s_arp_tready),
    .s_ip_tdata(s_ip_tdata), .s_ip_tvalid(s_ip_tvalid), .s_ip_tlast(s_ip_tlast), .s_ip_tready(s_ip_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    s_arp_tvalid = arp_q.size() > 0;
    s_arp_tdata = arp_q.size() > 0 ? arp_q[0] : 8'h00;
    s_arp_tlast = arp_q.size() == 1;
    s_ip_tvalid = ip_q.size() > 0;
    s_ip_tdata = ip_q.size() > 0 ? ip_q[0] : 8'h00;
    s_ip_tlast = ip_q.size() == 1;
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic clear();
    cyc = 0; arp_n = 0; ip_n = 0; out_n = 0; tl_n = 0; early_ip = 0;
    first_ip = -1; first_valid = -1;
    out_q.delete();
  endtask
  task automatic load(input bit ip, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      if (ip) ip_q.push_back(base + 8'(i));
      else arp_q.push_back(base + 8'(i));
    end
    drive();
  endtask
  task automatic tick();
    bit ah, ih, stall;
    logic [7:0] hd;
    logic hl;
    ah = s_arp_tvalid && s_arp_tready;
    ih = s_ip_tvalid && s_ip_tready;
    if (ih && first_ip < 0) first_ip = cyc;
    if (m_tvalid && first_valid < 0) first_valid = cyc;
    if (s_ip_tready && tl_n == 0) early_ip++;
    if (m_tvalid && m_tready) begin
      out_q.push_back({m_tlast, m_tdata});
      out_n++;
      if (m_tlast) tl_n++;
    end
    arp_n += int'(ah);
    ip_n += int'(ih);
    stall = m_tvalid && !m_tready;
    hd = m_tdata;
    hl = m_tlast;
    @(posedge tx_mac_aclk);
    #1;
    if (ah) void'(arp_q.pop_front());
    if (ih) void'(ip_q.pop_front());
    drive();
    #4;
    cyc++;
    if (stall) begin
      chk("hold valid", m_tvalid, 1);
      chk("hold data", m_tdata, hd);
      chk("hold last", m_tlast, hl);
    end
  endtask
  task automatic run(input int frames, input int budget);
    int n;
    n = 0;
    while (tl_n < frames && n < budget) begin
      tick();
      n++;
    end
    chk("frames done", tl_n, frames);
  endtask
  task automatic check_frame(input string tag, input logic [7:0] base, input int len);
    int exp_len, n, errs;
    bit got_last;
    logic [8:0] e;
    logic [7:0] eb;
    exp_len = len < 60 ? 60 : len;
    n = 0; errs = 0; got_last = 0;
    while (out_q.size() > 0 && !got_last) begin
      e = out_q.pop_front();
      eb = n < len ? base + 8'(n) : 8'h00;
      if (e[7:0] !== eb) errs++;
      got_last = e[8];
      n++;
    end
    chk({tag, " len"}, n, exp_len);
    chk({tag, " data errs"}, errs, 0);
  endtask
  initial begin
    tx_mac_reset = 1'b1;
    rnd = 0;
    drive();
    #3;
    chk("rst m_tdata", m_tdata, 0);
    chk("rst m_tvalid", m_tvalid, 0);
    chk("rst m_tlast", m_tlast, 0);
    chk("rst arp_tready", s_arp_tready, 0);
    chk("rst ip_tready", s_ip_tready, 0);
    repeat (2) @(posedge tx_mac_aclk);
    #1;
    tx_mac_reset = 1'b0;
    #4;
    clear();
    load(0, 8'h01, 42);
    run(1, 200);
    chk("t1 arp hs", arp_n, 42);
    chk("t1 out hs", out_n, 60);
    check_frame("t1 arp", 8'h01, 42);
    clear();
    load(1, 8'h10, 100);
    run(1, 300);
    chk("t2 ip hs", ip_n, 100);
    chk("t2 latency", first_valid - first_ip, 1);
    check_frame("t2 ip", 8'h10, 100);
    clear();
    load(0, 8'h01, 42);
    load(1, 8'h40, 60);
    run(2, 400);
    check_frame("t3 first arp", 8'h01, 42);
    check_frame("t3 second ip", 8'h40, 60);
    clear();
    load(0, 8'h01, 42);
    load(1, 8'h40, 60);
    run(2, 400);
    check_frame("t3b first ip", 8'h40, 60);
    check_frame("t3b second arp", 8'h01, 42);
    clear();
    rnd = 1;
    load(0, 8'h01, 42);
    run(1, 1000);
    rnd = 0;
    chk("t4 arp hs", arp_n, 42);
    chk("t4 out hs", out_n, 60);
    check_frame("t4 arp", 8'h01, 42);
    clear();
    load(0, 8'h01, 42);
    k = 0;
    while (arp_n < 5 && k < 50) begin
      tick();
      k++;
    end
    load(1, 8'h80, 70);
    run(2, 400);
    chk("t5 early ip ready", early_ip, 0);
    check_frame("t5 arp", 8'h01, 42);
    check_frame("t5 ip", 8'h80, 70);
    clear();
    load(0, 8'h01, 42);
    k = 0;
    while (arp_n < 20 && k < 50) begin
      tick();
      k++;
    end
    chk("t6 pre valid", m_tvalid, 1);
    tx_mac_reset = 1'b1;
    #1;
    chk("t6 rst m_tvalid", m_tvalid, 0);
    chk("t6 rst m_tlast", m_tlast, 0);
    chk("t6 rst arp_tready", s_arp_tready, 0);
    chk("t6 rst ip_tready", s_ip_tready, 0);
    @(posedge tx_mac_aclk);
    #1;
    arp_q.delete();
    ip_q.delete();
    clear();
    drive();
    tx_mac_reset = 1'b0;
    load(0, 8'h01, 42);
    #4;
    run(1, 200);
    chk("t6 arp hs", arp_n, 42);
    check_frame("t6 arp", 8'h01, 42);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
